// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI-lite read arbiter.
// Holds the arbiter FSM state encoding and the master index constants
// so the top level and the round-robin picker agree on who is who.
package axi_rd_arbiter_pkg;

   // Arbiter states: waiting for a request, presenting the address to the
   // RAM, and forwarding the read data back to the granted master.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_t;

   // Master indices as they appear on grant and in the picker
   localparam logic M_IFU = 1'b0;
   localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Two-way round-robin selector.
// Ports:
//   req  - request bits, req[0] from M0 (IFU), req[1] from M1 (LSU)
//   last - index of the master that completed the previous read
//   win  - index of the selected master (valid only when any=1)
//   any  - at least one request is pending
module rr_pick2
   import axi_rd_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       win,
   output logic       any
);

   // A lone requester always wins; on a tie the master that was not served
   // last takes the turn, which gives strict alternation under contention.
   always_comb begin
      any = |req;
      win = M_IFU;
      if (req == 2'b11) begin
         win = ~last;
      end else if (req[1]) begin
         win = M_LSU;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave arbiter for the AXI-lite read channels feeding the RAM.
// M0 is the instruction fetch unit, M1 the load/store unit. Only one read is
// outstanding at a time and the grant is held until the R handshake completes.
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   m0_ar*/m0_r*, m1_ar*/m1_r*   - master-side AR and R channels
//   s_ar*/s_r*                   - slave-side AR and R channels to the RAM
//   grant                        - current or most recent owner (0=M0, 1=M1)
//   busy                         - a read is in progress (ADDR or DATA state)
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_rvalid,
   output logic              s_rready,
   output logic              grant,
   output logic              busy
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              last;
   logic [ADDR_W-1:0] addr_q;
   logic              pick_win;
   logic              pick_any;
   logic              owner_rready;
   logic              ar_take;
   logic              r_done;

   rr_pick2 u_pick (
      .req  ({m1_arvalid, m0_arvalid}),
      .last (last),
      .win  (pick_win),
      .any  (pick_any)
   );

   // The winner's arready is combinational on its arvalid, so any pending
   // request seen in IDLE is a completed AR handshake this cycle.
   assign ar_take      = (state == ST_IDLE) && pick_any;
   assign owner_rready = (grant == M_LSU) ? m1_rready : m0_rready;
   assign r_done       = (state == ST_DATA) && s_rvalid && owner_rready;

   assign s_araddr = addr_q;
   assign busy     = (state != ST_IDLE);

   // State register plus the transaction bookkeeping. last starts at M1 so
   // the IFU wins the very first tie; it only moves when a read finishes,
   // which is what makes an abandoned (reset) read not count as a turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         last   <= M_LSU;
         grant  <= M_IFU;
         addr_q <= '0;
      end else begin
         state <= state_nxt;
         if (ar_take) begin
            addr_q <= (pick_win == M_LSU) ? m1_araddr : m0_araddr;
            grant  <= pick_win;
         end
         if (r_done) begin
            last <= grant;
         end
      end
   end

   // Next-state and handshake steering. Everything defaults to quiet, and
   // every valid/ready output is forced low while reset is asserted so a
   // half-finished transaction cannot leak out during the reset cycle.
   always_comb begin
      state_nxt  = state;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      m0_rdata   = '0;
      m1_rdata   = '0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  if (pick_win == M_LSU) begin
                     m1_arready = 1'b1;
                  end else begin
                     m0_arready = 1'b1;
                  end
                  state_nxt = ST_ADDR;
               end
            end
            ST_ADDR: begin
               s_arvalid = 1'b1;
               if (s_arready) begin
                  state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               s_rready = owner_rready;
               if (grant == M_LSU) begin
                  m1_rvalid = s_rvalid;
                  m1_rdata  = s_rdata;
               end else begin
                  m0_rvalid = s_rvalid;
                  m0_rdata  = s_rdata;
               end
               if (s_rvalid && owner_rready) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus a random
// phase, with a RAM model and a scoreboard monitor running alongside.
module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        mst_arvalid [2];
   logic [31:0] mst_araddr  [2];
   logic        mst_rready  [2];
   logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] s_araddr, s_rdata;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic        grant, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit sim_done = 0;
   bit rand_done = 0;
   bit ram_random = 0;
   bit ram_ready_fixed = 1;
   int ram_extra = 0;

   // Reference model of the arbiter at transaction level
   logic        outstanding, addr_sent, owner, last_served;
   logic [31:0] owner_addr;
   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];
   int          accept_log [$];
   int          accept_cyc [2];
   int          rdone_cyc [2];

   axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_araddr  (mst_araddr[0]),
      .m0_arvalid (mst_arvalid[0]),
      .m0_arready (m0_arready),
      .m0_rdata   (m0_rdata),
      .m0_rvalid  (m0_rvalid),
      .m0_rready  (mst_rready[0]),
      .m1_araddr  (mst_araddr[1]),
      .m1_arvalid (mst_arvalid[1]),
      .m1_arready (m1_arready),
      .m1_rdata   (m1_rdata),
      .m1_rvalid  (m1_rvalid),
      .m1_rready  (mst_rready[1]),
      .s_araddr   (s_araddr),
      .s_arvalid  (s_arvalid),
      .s_arready  (s_arready),
      .s_rdata    (s_rdata),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ramWord(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic rvalid_of(input logic m);
      return m ? m1_rvalid : m0_rvalid;
   endfunction

   function automatic logic [31:0] rdata_of(input logic m);
      return m ? m1_rdata : m0_rdata;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Present one read request from master m and hold it until accepted.
   // Called at posedge+1; returns at posedge+1 after the accepting cycle.
   task automatic applyStimulus(input int m, input logic [31:0] addr, output int waited);
      bit got = 0;
      waited = 0;
      mst_araddr[m]  = addr;
      mst_arvalid[m] = 1'b1;
      while (!got && waited < 300) begin
         @(negedge clk);
         waited++;
         got = (m == 0) ? m0_arready : m1_arready;
      end
      checkOutput("accept_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
      mst_arvalid[m] = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || outstanding) && n < 400);
      checkOutput("idle_timeout", 32'(busy || outstanding), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic setFastRam();
      ram_random      = 0;
      ram_ready_fixed = 1;
      ram_extra       = 0;
   endtask

   // RAM model: accepts an address, returns ramWord(addr) ram_extra+2 cycles
   // after the AR handshake and holds it until the R handshake.
   task automatic ramLoop();
      bit          ar_hs, r_hs, rst_s;
      logic [31:0] addr_s, pend;
      int          cnt = 0;
      pend = '0;
      while (!sim_done) begin
         @(negedge clk);
         ar_hs  = s_arvalid && s_arready;
         r_hs   = s_rvalid && s_rready;
         rst_s  = rst;
         addr_s = s_araddr;
         @(posedge clk); #1;
         if (rst_s) begin
            s_rvalid = 1'b0;
            s_rdata  = $urandom;
            cnt      = 0;
         end else begin
            if (r_hs) begin
               s_rvalid = 1'b0;
               s_rdata  = $urandom;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  s_rvalid = 1'b1;
                  s_rdata  = ramWord(pend);
               end
            end
            if (ar_hs) begin
               pend = addr_s;
               cnt  = (ram_random ? int'($urandom_range(0, 3)) : ram_extra) + 1;
            end
         end
         s_arready = ram_random ? 1'($urandom_range(0, 1)) : ram_ready_fixed;
      end
   endtask

   // Scoreboard monitor: checks every cycle against the transaction model.
   task automatic monitorLoop();
      logic        was_out, data_phase, addr_phase, exp_win, acc0, acc1;
      logic [31:0] exp_data;
      while (!sim_done) begin
         @(negedge clk);
         if (rst) begin
            outstanding = 1'b0;
            addr_sent   = 1'b0;
            last_served = 1'b1;
            exp_q0.delete();
            exp_q1.delete();
            continue;
         end
         was_out    = outstanding;
         data_phase = outstanding && addr_sent;
         addr_phase = outstanding && !addr_sent;
         acc0       = mst_arvalid[0] && m0_arready;
         acc1       = mst_arvalid[1] && m1_arready;
         checkOutput("busy", 32'(busy), 32'(was_out));
         checkOutput("s_arvalid", 32'(s_arvalid), 32'(addr_phase));
         checkOutput("s_rready", 32'(s_rready), 32'(data_phase && mst_rready[owner]));
         if (was_out) checkOutput("arready_while_busy", 32'({m1_arready, m0_arready}), 32'd0);
         if (addr_phase && s_arvalid && s_arready) begin
            checkOutput("s_araddr", s_araddr, owner_addr);
            addr_sent = 1'b1;
         end
         if (data_phase) begin
            checkOutput("grant", 32'(grant), 32'(owner));
            checkOutput("owner_rvalid", 32'(rvalid_of(owner)), 32'(s_rvalid));
            checkOutput("other_rvalid", 32'(rvalid_of(!owner)), 32'd0);
            checkOutput("other_rdata", rdata_of(!owner), 32'd0);
            if (s_rvalid && mst_rready[owner]) begin
               exp_data = 32'hDEAD_BEEF;
               if (owner == 1'b0) begin
                  checkOutput("sb_nonempty", 32'(exp_q0.size() != 0), 32'd1);
                  if (exp_q0.size() != 0) exp_data = exp_q0.pop_front();
               end else begin
                  checkOutput("sb_nonempty", 32'(exp_q1.size() != 0), 32'd1);
                  if (exp_q1.size() != 0) exp_data = exp_q1.pop_front();
               end
               checkOutput("rdata", rdata_of(owner), exp_data);
               outstanding      = 1'b0;
               addr_sent        = 1'b0;
               last_served      = owner;
               rdone_cyc[owner] = cyc;
            end
         end else begin
            checkOutput("rvalid_outside_data", 32'({m1_rvalid, m0_rvalid}), 32'd0);
         end
         if (!was_out && (mst_arvalid[0] || mst_arvalid[1])) begin
            exp_win = (mst_arvalid[0] && mst_arvalid[1]) ? !last_served : mst_arvalid[1];
            checkOutput("accept_winner", 32'({acc1, acc0}), exp_win ? 32'd2 : 32'd1);
            owner       = exp_win;
            owner_addr  = mst_araddr[exp_win];
            outstanding = 1'b1;
            addr_sent   = 1'b0;
            if (exp_win) exp_q1.push_back(ramWord(owner_addr));
            else         exp_q0.push_back(ramWord(owner_addr));
            accept_log.push_back(int'(exp_win));
            accept_cyc[exp_win] = cyc;
         end
      end
   endtask

   task automatic mainSequence();
      int          w, w0, w1, n;
      logic [31:0] hold;

      // Reset state, with both masters already requesting
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_m0_arready", 32'(m0_arready), 32'd0);
      checkOutput("rst_m1_arready", 32'(m1_arready), 32'd0);
      checkOutput("rst_s_arvalid", 32'(s_arvalid), 32'd0);
      checkOutput("rst_s_rready", 32'(s_rready), 32'd0);
      checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_grant", 32'(grant), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mst_arvalid[0] = 1'b0;
      mst_arvalid[1] = 1'b0;

      // Single M0 read and its latency
      applyStimulus(0, 32'h8000_0000, w);
      checkOutput("t1_accept_latency", 32'(w), 32'd1);
      @(negedge clk);
      checkOutput("t1_s_arvalid", 32'(s_arvalid), 32'd1);
      checkOutput("t1_s_araddr", s_araddr, 32'h8000_0000);
      @(negedge clk);
      checkOutput("t1_rvalid_early", 32'(m0_rvalid), 32'd0);
      @(negedge clk);
      checkOutput("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
      checkOutput("t1_m0_rdata", m0_rdata, ramWord(32'h8000_0000));
      checkOutput("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
      @(posedge clk); #1;
      waitIdle();

      // Simultaneous first requests after reset
      applyReset();
      accept_log.delete();
      fork
         applyStimulus(0, 32'h8000_0010, w0);
         applyStimulus(1, 32'h8000_0020, w1);
      join
      waitIdle();
      checkOutput("t2_m0_first", 32'(w0), 32'd1);
      checkOutput("t2_log_size", 32'(accept_log.size()), 32'd2);
      if (accept_log.size() >= 2) begin
         checkOutput("t2_first_grant", 32'(accept_log[0]), 32'd0);
         checkOutput("t2_second_grant", 32'(accept_log[1]), 32'd1);
      end
      checkOutput("t2_m1_after_r", 32'(accept_cyc[1]), 32'(rdone_cyc[0] + 1));
      checkOutput("t2_grant_held", 32'(grant), 32'd1);

      // Continuous contention: strict alternation
      accept_log.delete();
      fork
         begin
            int wa;
            for (int i = 0; i < 3; i++) applyStimulus(0, 32'h8000_1000 + 32'(i * 4), wa);
         end
         begin
            int wb;
            for (int i = 0; i < 3; i++) applyStimulus(1, 32'h8000_2000 + 32'(i * 4), wb);
         end
      join
      waitIdle();
      checkOutput("t3_log_size", 32'(accept_log.size()), 32'd6);
      for (int i = 0; i < accept_log.size(); i++)
         checkOutput("t3_grant_seq", 32'(accept_log[i]), 32'(i % 2));

      // Back-pressure on M1 with M0 waiting
      mst_rready[1] = 1'b0;
      applyStimulus(1, 32'h8000_0300, w);
      mst_araddr[0]  = 32'h8000_0400;
      mst_arvalid[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m1_rvalid && n < 50);
      checkOutput("t4_rvalid_seen", 32'(m1_rvalid), 32'd1);
      hold = m1_rdata;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput("t4_s_rready", 32'(s_rready), 32'd0);
         checkOutput("t4_rdata_stable", m1_rdata, hold);
         checkOutput("t4_busy", 32'(busy), 32'd1);
         checkOutput("t4_m0_held", 32'(m0_arready), 32'd0);
      end
      @(posedge clk); #1;
      mst_rready[1] = 1'b1;
      @(negedge clk);
      checkOutput("t4_s_rready_rel", 32'(s_rready), 32'd1);
      checkOutput("t4_m0_held_last", 32'(m0_arready), 32'd0);
      @(negedge clk);
      checkOutput("t4_m0_accept", 32'(m0_arready), 32'd1);
      @(posedge clk); #1;
      mst_arvalid[0] = 1'b0;
      waitIdle();

      // Reset while in ADDR
      ram_ready_fixed = 0;
      applyStimulus(1, 32'h8000_0100, w);
      @(negedge clk);
      checkOutput("t5_in_addr", 32'(s_arvalid), 32'd1);
      @(posedge clk); #1;
      rst            = 1'b1;
      mst_araddr[0]  = 32'h8000_0500;
      mst_arvalid[0] = 1'b1;
      @(negedge clk);
      checkOutput("t5_rst_arready", 32'({m1_arready, m0_arready}), 32'd0);
      checkOutput("t5_rst_s_arvalid", 32'(s_arvalid), 32'd0);
      @(posedge clk); #1;
      rst             = 1'b0;
      mst_arvalid[0]  = 1'b0;
      ram_ready_fixed = 1;
      @(negedge clk);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      checkOutput("t5_s_arvalid", 32'(s_arvalid), 32'd0);
      checkOutput("t5_arready", 32'({m1_arready, m0_arready}), 32'd0);
      @(posedge clk); #1;
      applyStimulus(1, 32'h8000_0104, w);
      checkOutput("t5_new_accept", 32'(w), 32'd1);
      waitIdle();

      // M0 arrives during a long M1 DATA phase
      ram_extra = 3;
      applyStimulus(1, 32'h8000_0600, w);
      @(posedge clk); #1;
      mst_araddr[0]  = 32'h8000_0700;
      mst_arvalid[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checkOutput("t6_m0_held", 32'(m0_arready), 32'd0);
      end while (!(m1_rvalid && mst_rready[1]) && n < 50);
      @(negedge clk);
      checkOutput("t6_m0_accept", 32'(m0_arready), 32'd1);
      @(posedge clk); #1;
      mst_arvalid[0] = 1'b0;
      waitIdle();

      // Random traffic: random RAM timing, gaps and back-pressure
      ram_random = 1;
      rand_done  = 0;
      fork
         begin
            fork
               begin
                  int wa;
                  for (int i = 0; i < 12; i++) begin
                     applyStimulus(0, $urandom & 32'hFFFF_FFFC, wa);
                     repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                  end
               end
               begin
                  int wb;
                  for (int i = 0; i < 12; i++) begin
                     applyStimulus(1, $urandom & 32'hFFFF_FFFC, wb);
                     repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                  end
               end
            join
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               mst_rready[0] = ($urandom_range(0, 3) != 0);
               mst_rready[1] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      mst_rready[0] = 1'b1;
      mst_rready[1] = 1'b1;
      waitIdle();
      setFastRam();
   endtask

   initial begin
      rst            = 1'b1;
      mst_arvalid[0] = 1'b1;
      mst_arvalid[1] = 1'b1;
      mst_araddr[0]  = 32'h1234_5678;
      mst_araddr[1]  = 32'h9ABC_DEF0;
      mst_rready[0]  = 1'b1;
      mst_rready[1]  = 1'b1;
      s_arready      = 1'b0;
      s_rvalid       = 1'b0;
      s_rdata        = 32'h0BAD_F00D;
      outstanding    = 1'b0;
      addr_sent      = 1'b0;
      owner          = 1'b0;
      last_served    = 1'b1;
      owner_addr     = '0;
      accept_cyc     = '{0, 0};
      rdone_cyc      = '{0, 0};
      setFastRam();
      $display("[TB] starting axi_rd_arbiter bench");
      fork
         monitorLoop();
         ramLoop();
         begin
            mainSequence();
            sim_done = 1;
         end
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
